// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// ----------------
// Fetch stage: generates the fetch PC, issues I-cache requests, redecodes JAL
// to redirect the fetch PC early, and buffers fetched {pc, instr} pairs in a
// DEPTH-entry FIFO that feeds decode.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   csr_redirect_req/wfi_req    CSR/trap redirect, WFI redirect-then-sleep
//   csr_redirect_pc             target for csr_redirect_req and wfi_req
//   exe_redirect_req/_pc        branch/jalr redirect from execute
//   irq_wake                    leaves SLEEP
//   irq_req_next                discard this cycle's cache response
//   if_stall                    hold off new cache requests
//   if2ic_req/if2ic_addr        I-cache request and address (= fetch_pc)
//   ic2if_ack/ic2if_rdata       same-cycle cache response
//   if2id_valid/_instr/_pc/_pc_plus_4, id2if_ready   decode handshake
//
// Handshake: a transfer to decode happens on every clock edge where
// if2id_valid and id2if_ready are both high. if2id_valid never depends on
// id2if_ready, and the head fields stay stable while valid is high and
// ready is low (unless a redirect flushes the queue).
module fetch_queue_unit #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] PC_RESET  = 32'h0000_0000,
    parameter logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_redirect_req,
    input  logic            wfi_req,
    input  logic [XLEN-1:0] csr_redirect_pc,
    input  logic            exe_redirect_req,
    input  logic [XLEN-1:0] exe_redirect_pc,
    input  logic            irq_wake,
    input  logic            irq_req_next,
    input  logic            if_stall,
    output logic            if2ic_req,
    output logic [XLEN-1:0] if2ic_addr,
    input  logic            ic2if_ack,
    input  logic [XLEN-1:0] ic2if_rdata,
    output logic            if2id_valid,
    output logic [XLEN-1:0] if2id_instr,
    output logic [XLEN-1:0] if2id_pc,
    output logic [XLEN-1:0] if2id_pc_plus_4,
    input  logic            id2if_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        FETCH = 1'b0,
        SLEEP = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc, fetch_pc_d;
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic            redirect;
    logic            full;
    logic            push;
    logic            pop;
    logic            is_jal;
    logic [XLEN-1:0] jal_imm;

    assign redirect = csr_redirect_req | wfi_req | exe_redirect_req;
    assign full     = (count == CW'(DEPTH));

    // Gated by rst_n so the request is low while reset is held.
    assign if2ic_req  = rst_n & (state_q == FETCH) & ~if_stall & ~full & ~redirect;
    assign if2ic_addr = fetch_pc;

    // A response flagged by irq_req_next is dropped and fetch_pc is kept, so
    // the same address is requested again later.
    assign push = if2ic_req & ic2if_ack & ~irq_req_next;
    assign pop  = if2id_valid & id2if_ready;

    assign is_jal  = (ic2if_rdata[6:0] == 7'b1101111);
    assign jal_imm = {{(XLEN-20){ic2if_rdata[31]}}, ic2if_rdata[19:12],
                      ic2if_rdata[20], ic2if_rdata[30:21], 1'b0};

    assign if2id_valid     = (count != '0);
    assign if2id_instr     = if2id_valid ? mem_instr[rd_ptr] : INSTR_NOP;
    assign if2id_pc        = if2id_valid ? mem_pc[rd_ptr] : '0;
    assign if2id_pc_plus_4 = if2id_pc + XLEN'(4);

    // Next state and next fetch PC; redirect priority csr > wfi > exe.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc;
        if (csr_redirect_req) begin
            state_d    = FETCH;
            fetch_pc_d = csr_redirect_pc;
        end else if (wfi_req) begin
            state_d    = SLEEP;
            fetch_pc_d = csr_redirect_pc;
        end else begin
            if (exe_redirect_req) begin
                fetch_pc_d = exe_redirect_pc;
            end else if (push) begin
                fetch_pc_d = is_jal ? (fetch_pc + jal_imm) : (fetch_pc + XLEN'(4));
            end
            if ((state_q == SLEEP) && irq_wake) begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            fetch_pc <= PC_RESET;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state_q  <= state_d;
            fetch_pc <= fetch_pc_d;
            if (redirect) begin
                // Flush: any same-cycle pop is discarded too.
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only read while count covers them.
    // push is already low in any redirect cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= fetch_pc;
            mem_instr[wr_ptr] <= ic2if_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

    localparam int          XLEN      = 32;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] PC_RESET  = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        csr_redirect_req;
    logic        wfi_req;
    logic [31:0] csr_redirect_pc;
    logic        exe_redirect_req;
    logic [31:0] exe_redirect_pc;
    logic        irq_wake;
    logic        irq_req_next;
    logic        if_stall;
    logic        if2ic_req;
    logic [31:0] if2ic_addr;
    logic        ic2if_ack;
    logic [31:0] ic2if_rdata;
    logic        if2id_valid;
    logic [31:0] if2id_instr;
    logic [31:0] if2id_pc;
    logic [31:0] if2id_pc_plus_4;
    logic        id2if_ready;

    fetch_queue_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .PC_RESET(PC_RESET), .INSTR_NOP(INSTR_NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_redirect_req(csr_redirect_req), .wfi_req(wfi_req),
        .csr_redirect_pc(csr_redirect_pc),
        .exe_redirect_req(exe_redirect_req), .exe_redirect_pc(exe_redirect_pc),
        .irq_wake(irq_wake), .irq_req_next(irq_req_next), .if_stall(if_stall),
        .if2ic_req(if2ic_req), .if2ic_addr(if2ic_addr),
        .ic2if_ack(ic2if_ack), .ic2if_rdata(ic2if_rdata),
        .if2id_valid(if2id_valid), .if2id_instr(if2id_instr),
        .if2id_pc(if2id_pc), .if2id_pc_plus_4(if2id_pc_plus_4),
        .id2if_ready(id2if_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Queue of {pc, instr}; head is element 0.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    bit          m_sleep;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] jal_target(input logic [31:0] pc, input logic [31:0] r);
        int off;
        off = int'({22'b0, r[30:21]}) * 2
            + int'({31'b0, r[20]}) * 2048
            + int'({24'b0, r[19:12]}) * 4096
            - (r[31] ? 1048576 : 0);
        return pc + 32'(off);
    endfunction

    function automatic bit exp_req();
        return rst_n && !m_sleep && !if_stall && (exp_q.size() < DEPTH)
            && !(csr_redirect_req || wfi_req || exe_redirect_req);
    endfunction

    task automatic model_reset();
        m_pc    = PC_RESET;
        m_sleep = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        logic [31:0] hp, hi;
        hp = (exp_q.size() > 0) ? exp_q[0][63:32] : 32'h0;
        hi = (exp_q.size() > 0) ? exp_q[0][31:0]  : INSTR_NOP;
        chk("if2ic_req",       {31'b0, if2ic_req},   {31'b0, exp_req()});
        chk("if2ic_addr",      if2ic_addr,           m_pc);
        chk("if2id_valid",     {31'b0, if2id_valid}, {31'b0, exp_q.size() > 0});
        chk("if2id_instr",     if2id_instr,          hi);
        chk("if2id_pc",        if2id_pc,             hp);
        chk("if2id_pc_plus_4", if2id_pc_plus_4,      hp + 32'd4);
    endtask

    task automatic model_update();
        bit req;
        req = exp_req();
        if (!rst_n) begin
            model_reset();
        end else if (csr_redirect_req) begin
            m_pc = csr_redirect_pc; exp_q.delete(); m_sleep = 0;
        end else if (wfi_req) begin
            m_pc = csr_redirect_pc; exp_q.delete(); m_sleep = 1;
        end else if (exe_redirect_req) begin
            m_pc = exe_redirect_pc; exp_q.delete();
            if (m_sleep && irq_wake) m_sleep = 0;
        end else begin
            if (exp_q.size() > 0 && id2if_ready) void'(exp_q.pop_front());
            if (req && ic2if_ack && !irq_req_next) begin
                exp_q.push_back({m_pc, ic2if_rdata});
                m_pc = (ic2if_rdata[6:0] == 7'b1101111) ? jal_target(m_pc, ic2if_rdata)
                                                         : m_pc + 32'd4;
            end
            if (m_sleep && irq_wake) m_sleep = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge with inputs already set: check, clock, update model.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_pc_plus_4", if2id_pc_plus_4, 32'd4);
        chk("rst_addr", if2ic_addr, PC_RESET);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_inputs();
        csr_redirect_req = 0; wfi_req = 0; exe_redirect_req = 0;
        irq_wake = 0; irq_req_next = 0; if_stall = 0;
        ic2if_ack = 0; id2if_ready = 0; ic2if_rdata = INSTR_NOP;
    endtask

    task automatic redirect_exe(input logic [31:0] pc);
        exe_redirect_req = 1; exe_redirect_pc = pc;
        cycle();
        exe_redirect_req = 0;
    endtask

    task automatic randomize_inputs();
        logic [31:0] r;
        csr_redirect_req = ($urandom_range(0, 49) == 0);
        wfi_req          = ($urandom_range(0, 59) == 0);
        exe_redirect_req = ($urandom_range(0, 19) == 0);
        irq_wake         = ($urandom_range(0, 7) == 0);
        irq_req_next     = ($urandom_range(0, 5) == 0);
        if_stall         = ($urandom_range(0, 7) == 0);
        ic2if_ack        = ($urandom_range(0, 3) != 0);
        id2if_ready      = ($urandom_range(0, 2) != 0);
        r = $urandom(); r[1:0] = 2'b00; csr_redirect_pc = r;
        r = $urandom(); r[1:0] = 2'b00; exe_redirect_pc = r;
        r = $urandom();
        if ($urandom_range(0, 4) == 0) r[6:0] = 7'b1101111;
        else                            r[6:0] = 7'b0010011;
        ic2if_rdata = r;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0;
        csr_redirect_pc = '0; exe_redirect_pc = '0;
        clear_inputs();
        model_reset();
        @(negedge clk);

        // Sequential NOPs with ack and ready always high.
        do_reset();
        ic2if_ack = 1; id2if_ready = 1;
        cycle();
        #1; chk("seq_head_pc0", if2id_pc, 32'h0);
        repeat (6) cycle();

        // Decode stalled: four pushes fill the queue, then requests stop.
        do_reset();
        ic2if_ack = 1; id2if_ready = 0;
        repeat (6) cycle();
        #1;
        chk("full_req_low", {31'b0, if2ic_req}, 32'd0);
        chk("full_head_pc", if2id_pc, 32'h0);
        id2if_ready = 1;
        cycle();
        id2if_ready = 0;
        #1;
        chk("refill_req", {31'b0, if2ic_req}, 32'd1);
        chk("refill_addr", if2ic_addr, 32'h10);
        cycle();
        cycle();

        // JAL redecode. 0x1000006F is jal +0x100; 0x0100006F is jal +0x10.
        id2if_ready = 1;
        redirect_exe(32'h20);
        ic2if_rdata = 32'h1000_006F;
        cycle();
        #1;
        chk("jal_addr_120", if2ic_addr, 32'h120);
        chk("jal_entry_pc", if2id_pc, 32'h20);
        redirect_exe(32'h20);
        ic2if_rdata = 32'h0100_006F;
        cycle();
        #1; chk("jal_addr_30", if2ic_addr, 32'h30);
        ic2if_rdata = INSTR_NOP;

        // exe redirect with three entries queued and a same-cycle ack.
        id2if_ready = 0;
        redirect_exe(32'h100);
        repeat (3) cycle();
        exe_redirect_req = 1; exe_redirect_pc = 32'h400;
        cycle();
        exe_redirect_req = 0;
        #1;
        chk("exe_flush_addr", if2ic_addr, 32'h400);
        chk("exe_flush_valid", {31'b0, if2id_valid}, 32'd0);
        repeat (3) cycle();
        csr_redirect_req = 1; csr_redirect_pc = 32'h80;
        exe_redirect_req = 1; exe_redirect_pc = 32'h400;
        cycle();
        csr_redirect_req = 0; exe_redirect_req = 0;
        #1; chk("csr_wins_addr", if2ic_addr, 32'h80);

        // WFI sleep, then interrupt wake.
        id2if_ready = 1;
        wfi_req = 1; csr_redirect_pc = 32'h200;
        cycle();
        wfi_req = 0;
        repeat (10) begin
            cycle();
            chk("sleep_req_low", {31'b0, if2ic_req}, 32'd0);
        end
        irq_wake = 1;
        cycle();
        irq_wake = 0;
        #1;
        chk("wake_addr", if2ic_addr, 32'h200);
        chk("wake_req", {31'b0, if2ic_req}, 32'd1);

        // Response suppressed by irq_req_next is refetched.
        redirect_exe(32'h40);
        irq_req_next = 1;
        cycle();
        irq_req_next = 0;
        #1;
        chk("irq_next_refetch", if2ic_addr, 32'h40);
        chk("irq_next_nopush", {31'b0, if2id_valid}, 32'd0);
        cycle();

        // Reset asserted mid-operation with a partially full queue.
        id2if_ready = 0;
        repeat (2) cycle();
        do_reset();

        // Randomized traffic against the model, with one mid-run reset.
        for (int i = 0; i < 500; i++) begin
            randomize_inputs();
            if (i == 250) do_reset();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
